// File: rtl/prog_loader.sv
// prog_loader: streams a host program image into CPU memory while holding the
// CPU in reset, then releases the CPU and counts its run cycles until it halts.
//
// Ports
//   clk        in   system clock (shared with the CPU control logic)
//   rst_       in   synchronous active-high reset
//   start      in   begin an image load (honoured in IDLE and DONE only)
//   in_valid   in   host byte valid
//   in_data    in   host program byte
//   in_last    in   final byte of a short image (qualified by in_valid)
//   in_ready   out  loader accepts a byte this cycle
//   mem_addr   out  memory write address
//   mem_data   out  memory write data
//   mem_wr     out  memory write strobe, one cycle per accepted byte
//   cpu_rst_   out  active-low CPU reset
//   halt       in   CPU halt indication
//   busy       out  high in LOAD, FLUSH and RUN
//   run_done   out  high in DONE
//   timeout    out  sticky: run ended by the watchdog
//   cycles     out  CPU run-cycle count (saturating)
//
// Configuration macro: PROG_LOADER_WDOG_EN enables the run-cycle watchdog.
// Without it timeout is held at 0 and RUN only exits on halt.

module prog_loader #(
    parameter int unsigned      DEPTH      = 32,
    parameter int unsigned      CNT_W      = 16,
    parameter logic [CNT_W-1:0] WDOG_LIMIT = 16'd4000
) (
    input  logic                     clk,
    input  logic                     rst_,
    input  logic                     start,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    output logic [$clog2(DEPTH)-1:0] mem_addr,
    output logic [7:0]               mem_data,
    output logic                     mem_wr,
    output logic                     cpu_rst_,
    input  logic                     halt,
    output logic                     busy,
    output logic                     run_done,
    output logic                     timeout,
    output logic [CNT_W-1:0]         cycles
);

    localparam int unsigned      AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]    LastAddr = AW'(DEPTH - 1);

`ifdef PROG_LOADER_WDOG_EN
    localparam logic [CNT_W-1:0] WdogLast = WDOG_LIMIT - 1'b1;
`else
    logic unused_wdog_limit;
    assign unused_wdog_limit = ^WDOG_LIMIT;
`endif

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StFlush,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [AW-1:0]     mem_addr_q, mem_addr_d;
    logic [7:0]        mem_data_q, mem_data_d;
    logic              mem_wr_q, mem_wr_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              timeout_q, timeout_d;
    logic              in_ready_q, in_ready_d;
    logic              cpu_rst_n_q, cpu_rst_n_d;
    logic              busy_q, busy_d;
    logic              run_done_q, run_done_d;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        mem_wr_d   = 1'b0;
        cycles_d   = cycles_q;
        timeout_d  = timeout_q;

        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    state_d   = StLoad;
                    addr_d    = '0;
                    cycles_d  = '0;
                    timeout_d = 1'b0;
                end
            end
            StLoad: begin
                // in_ready is always high in LOAD, so in_valid alone is a transfer
                if (in_valid) begin
                    mem_addr_d = addr_q;
                    mem_data_d = in_data;
                    mem_wr_d   = 1'b1;
                    addr_d     = addr_q + 1'b1;
                    if (addr_q == LastAddr || in_last) begin
                        state_d = StFlush;
                    end
                end
            end
            // One dead cycle lets the final write land while the CPU is still in reset
            StFlush: begin
                state_d = StRun;
            end
            StRun: begin
                if (halt) begin
                    state_d = StDone;
                end else begin
                    if (cycles_q != '1) begin
                        cycles_d = cycles_q + 1'b1;
                    end
`ifdef PROG_LOADER_WDOG_EN
                    if (cycles_q == WdogLast) begin
                        state_d   = StDone;
                        timeout_d = 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase

`ifndef PROG_LOADER_WDOG_EN
        timeout_d = 1'b0;
`endif

        // Outputs are registered from the next state so they align with state_q
        in_ready_d  = (state_d == StLoad);
        busy_d      = (state_d == StLoad) || (state_d == StFlush) || (state_d == StRun);
        run_done_d  = (state_d == StDone);
        cpu_rst_n_d = (state_d == StRun) || (state_d == StDone);
    end

    always_ff @(posedge clk) begin
        if (rst_) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            mem_wr_q    <= 1'b0;
            cycles_q    <= '0;
            timeout_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            cpu_rst_n_q <= 1'b0;
            busy_q      <= 1'b0;
            run_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            mem_wr_q    <= mem_wr_d;
            cycles_q    <= cycles_d;
            timeout_q   <= timeout_d;
            in_ready_q  <= in_ready_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            busy_q      <= busy_d;
            run_done_q  <= run_done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign mem_addr = mem_addr_q;
    assign mem_data = mem_data_q;
    assign mem_wr   = mem_wr_q;
    assign cpu_rst_ = cpu_rst_n_q;
    assign busy     = busy_q;
    assign run_done = run_done_q;
    assign timeout  = timeout_q;
    assign cycles   = cycles_q;

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader. Expected memory writes are queued as
// bytes are driven and popped by a monitor whenever mem_wr is seen.
// Watchdog expectations follow PROG_LOADER_WDOG_EN as compiled.

module tb_prog_loader;

    localparam int unsigned DEPTH = 32;
    localparam int unsigned CNT_W = 16;

    logic             clk;
    logic             rst_;
    logic             start;
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic [4:0]       mem_addr;
    logic [7:0]       mem_data;
    logic             mem_wr;
    logic             cpu_rst_;
    logic             halt;
    logic             busy;
    logic             run_done;
    logic             timeout;
    logic [CNT_W-1:0] cycles;

    prog_loader #(
        .DEPTH      (DEPTH),
        .CNT_W      (CNT_W),
        .WDOG_LIMIT (16'd20)
    ) dut (
        .clk      (clk),
        .rst_     (rst_),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_last  (in_last),
        .in_ready (in_ready),
        .mem_addr (mem_addr),
        .mem_data (mem_data),
        .mem_wr   (mem_wr),
        .cpu_rst_ (cpu_rst_),
        .halt     (halt),
        .busy     (busy),
        .run_done (run_done),
        .timeout  (timeout),
        .cycles   (cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          n_wr  = 0;
    logic [12:0] exp_q[$];
    logic [12:0] exp_w;

    // Scoreboard monitor: every write must match the oldest expected {addr,data}
    always @(negedge clk) begin
        if (mem_wr === 1'b1) begin
            n_wr++;
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_wr: got addr=%0d data=%02h, required no write",
                         mem_addr, mem_data);
            end else begin
                exp_w = exp_q.pop_front();
                if ({mem_addr, mem_data} !== exp_w) begin
                    n_bad++;
                    $display("FAIL wr_data: got addr=%0d data=%02h, required addr=%0d data=%02h",
                             mem_addr, mem_data, exp_w[12:8], exp_w[7:0]);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_ = 1'b1;
        step();
        step();
        n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL rst_in_ready: got %b required 0", in_ready); end
        n_cmp++; if (cpu_rst_ !== 1'b0) begin n_bad++; $display("FAIL rst_cpu_rst: got %b required 0", cpu_rst_); end
        n_cmp++; if (mem_wr !== 1'b0) begin n_bad++; $display("FAIL rst_mem_wr: got %b required 0", mem_wr); end
        n_cmp++; if (mem_addr !== 5'd0) begin n_bad++; $display("FAIL rst_mem_addr: got %0d required 0", mem_addr); end
        n_cmp++; if (mem_data !== 8'd0) begin n_bad++; $display("FAIL rst_mem_data: got %0d required 0", mem_data); end
        n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %b required 0", busy); end
        n_cmp++; if (run_done !== 1'b0) begin n_bad++; $display("FAIL rst_run_done: got %b required 0", run_done); end
        n_cmp++; if (timeout !== 1'b0) begin n_bad++; $display("FAIL rst_timeout: got %b required 0", timeout); end
        n_cmp++; if (cycles !== '0) begin n_bad++; $display("FAIL rst_cycles: got %0d required 0", cycles); end
        rst_ = 1'b0;
        step();
    endtask

    // 32 back-to-back bytes with addr == data
    task automatic test_full_load();
        do_start();
        n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b1 || cpu_rst_ !== 1'b0) begin
            n_bad++; $display("FAIL load_entry: got ready=%b busy=%b cpu_rst_=%b required 1 1 0", in_ready, busy, cpu_rst_);
        end
        n_wr = 0;
        for (int i = 0; i < 32; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            in_last  = 1'b0;
            exp_q.push_back({5'(i), 8'(i)});
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (mem_wr !== 1'b1 || in_ready !== 1'b0 || cpu_rst_ !== 1'b0 || busy !== 1'b1) begin
            n_bad++; $display("FAIL flush: got wr=%b ready=%b cpu_rst_=%b busy=%b required 1 0 0 1", mem_wr, in_ready, cpu_rst_, busy);
        end
        step();
        n_cmp++; if (cpu_rst_ !== 1'b1 || mem_wr !== 1'b0) begin
            n_bad++; $display("FAIL run_release: got cpu_rst_=%b wr=%b required 1 0", cpu_rst_, mem_wr);
        end
        n_cmp++; if (n_wr !== 32 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL full_count: got %0d writes (%0d pending) required 32 (0)", n_wr, exp_q.size());
        end
    endtask

    // Halt 10 cycles after RUN entry; start inside RUN must be ignored
    task automatic test_halt();
        n_cmp++; if (cycles !== 16'd0) begin n_bad++; $display("FAIL run_cyc0: got %0d required 0", cycles); end
        for (int i = 0; i < 4; i++) step();
        start = 1'b1;
        step();
        start = 1'b0;
        n_cmp++; if (cycles !== 16'd5 || busy !== 1'b1 || cpu_rst_ !== 1'b1 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL start_in_run: got cyc=%0d busy=%b cpu_rst_=%b ready=%b required 5 1 1 0", cycles, busy, cpu_rst_, in_ready);
        end
        for (int i = 0; i < 5; i++) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_cmp++; if (run_done !== 1'b1 || busy !== 1'b0 || cycles !== 16'd10 || timeout !== 1'b0 || cpu_rst_ !== 1'b1) begin
            n_bad++; $display("FAIL halt_done: got done=%b busy=%b cyc=%0d to=%b cpu_rst_=%b required 1 0 10 0 1", run_done, busy, cycles, timeout, cpu_rst_);
        end
        step();
        step();
        n_cmp++; if (cycles !== 16'd10 || run_done !== 1'b1) begin
            n_bad++; $display("FAIL done_hold: got cyc=%0d done=%b required 10 1", cycles, run_done);
        end
        do_start();
        n_cmp++; if (busy !== 1'b1 || cycles !== 16'd0 || cpu_rst_ !== 1'b0 || in_ready !== 1'b1 || run_done !== 1'b0) begin
            n_bad++; $display("FAIL restart: got busy=%b cyc=%0d cpu_rst_=%b ready=%b done=%b required 1 0 0 1 0", busy, cycles, cpu_rst_, in_ready, run_done);
        end
    endtask

    // in_valid every other cycle; addresses must stay contiguous
    task automatic test_throttle();
        logic [4:0] a;
        a    = 5'd0;
        n_wr = 0;
        for (int i = 0; i < 64; i++) begin
            in_valid = ((i % 2) == 0);
            in_data  = 8'($urandom);
            in_last  = 1'b0;
            if (in_valid) begin
                exp_q.push_back({a, in_data});
                a = a + 5'd1;
            end
            step();
        end
        in_valid = 1'b0;
        n_cmp++; if (n_wr !== 32 || exp_q.size() != 0 || cpu_rst_ !== 1'b1 || busy !== 1'b1) begin
            n_bad++; $display("FAIL throttle: got %0d writes (%0d pending) cpu_rst_=%b busy=%b required 32 (0) 1 1", n_wr, exp_q.size(), cpu_rst_, busy);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
    endtask

    // Five bytes with in_last on the fifth; valid bytes after load are ignored
    task automatic test_short_image();
        do_start();
        n_wr = 0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 8'hA0 + 8'(i);
            in_last  = (i == 4);
            exp_q.push_back({5'(i), in_data});
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        n_cmp++; if (in_ready !== 1'b0 || mem_wr !== 1'b1 || mem_addr !== 5'd4 || cpu_rst_ !== 1'b0) begin
            n_bad++; $display("FAIL short_flush: got ready=%b wr=%b addr=%0d cpu_rst_=%b required 0 1 4 0", in_ready, mem_wr, mem_addr, cpu_rst_);
        end
        step();
        n_cmp++; if (cpu_rst_ !== 1'b1 || busy !== 1'b1 || n_wr !== 5 || exp_q.size() != 0) begin
            n_bad++; $display("FAIL short_run: got cpu_rst_=%b busy=%b writes=%0d required 1 1 5", cpu_rst_, busy, n_wr);
        end
        in_valid = 1'b1;
        halt     = 1'b1;
        step();
        halt = 1'b0;
        step();
        step();
        in_valid = 1'b0;
        n_cmp++; if (run_done !== 1'b1 || cycles !== 16'd0 || n_wr !== 5 || in_ready !== 1'b0) begin
            n_bad++; $display("FAIL short_done: got done=%b cyc=%0d writes=%0d ready=%b required 1 0 5 0", run_done, cycles, n_wr, in_ready);
        end
    endtask

    // One-byte image, then run with no halt past the 20-cycle watchdog limit
    task automatic test_watchdog();
        do_start();
        in_valid = 1'b1;
        in_data  = 8'h5A;
        in_last  = 1'b1;
        exp_q.push_back({5'd0, 8'h5A});
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        for (int i = 0; i < 19; i++) step();
        n_cmp++; if (cycles !== 16'd19 || busy !== 1'b1 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL wdog_pre: got cyc=%0d busy=%b to=%b required 19 1 0", cycles, busy, timeout);
        end
        step();
`ifdef PROG_LOADER_WDOG_EN
        n_cmp++; if (run_done !== 1'b1 || timeout !== 1'b1 || cycles !== 16'd20 || busy !== 1'b0) begin
            n_bad++; $display("FAIL wdog_fire: got done=%b to=%b cyc=%0d busy=%b required 1 1 20 0", run_done, timeout, cycles, busy);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (cycles !== 16'd20 || timeout !== 1'b1) begin
            n_bad++; $display("FAIL wdog_hold: got cyc=%0d to=%b required 20 1", cycles, timeout);
        end
        // halt coinciding with the limit wins
        do_start();
        in_valid = 1'b1;
        in_data  = 8'h33;
        in_last  = 1'b1;
        exp_q.push_back({5'd0, 8'h33});
        step();
        in_valid = 1'b0;
        in_last  = 1'b0;
        step();
        for (int i = 0; i < 19; i++) step();
        halt = 1'b1;
        step();
        halt = 1'b0;
        n_cmp++; if (run_done !== 1'b1 || timeout !== 1'b0 || cycles !== 16'd19) begin
            n_bad++; $display("FAIL wdog_halt_wins: got done=%b to=%b cyc=%0d required 1 0 19", run_done, timeout, cycles);
        end
`else
        n_cmp++; if (run_done !== 1'b0 || busy !== 1'b1 || cycles !== 16'd20) begin
            n_bad++; $display("FAIL nowdog_run: got done=%b busy=%b cyc=%0d required 0 1 20", run_done, busy, cycles);
        end
        for (int i = 0; i < 5; i++) step();
        n_cmp++; if (cycles !== 16'd25 || busy !== 1'b1 || timeout !== 1'b0) begin
            n_bad++; $display("FAIL nowdog_hold: got cyc=%0d busy=%b to=%b required 25 1 0", cycles, busy, timeout);
        end
        halt = 1'b1;
        step();
        halt = 1'b0;
`endif
    endtask

    // Reset arriving with byte 12 aborts the load
    task automatic test_reset_mid_load();
        do_start();
        n_wr = 0;
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1;
            in_data  = 8'h40 + 8'(i);
            exp_q.push_back({5'(i), in_data});
            step();
        end
        in_data = 8'h4C;
        rst_    = 1'b1;
        step();
        n_cmp++; if (mem_wr !== 1'b0 || cpu_rst_ !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0 || mem_addr !== 5'd0) begin
            n_bad++; $display("FAIL midload_rst: got wr=%b cpu_rst_=%b ready=%b busy=%b addr=%0d required 0 0 0 0 0", mem_wr, cpu_rst_, in_ready, busy, mem_addr);
        end
        rst_ = 1'b0;
        for (int i = 0; i < 4; i++) step();
        in_valid = 1'b0;
        n_cmp++; if (n_wr !== 12 || exp_q.size() != 0 || in_ready !== 1'b0 || busy !== 1'b0) begin
            n_bad++; $display("FAIL midload_after: got writes=%0d pending=%0d ready=%b busy=%b required 12 0 0 0", n_wr, exp_q.size(), in_ready, busy);
        end
    endtask

    initial begin
        rst_     = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        in_last  = 1'b0;
        halt     = 1'b0;
        test_reset();
        test_full_load();
        test_halt();
        test_throttle();
        test_short_image();
        test_watchdog();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
